// File: rtl/timer_event_unit_if.sv
// Bus bundle between the timer/counter core, the event unit and the CPU/interrupt side.
// master drives the live count and control; slave (the event unit) returns status.
interface timer_event_unit_if #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned OVC_WIDTH = 8
);
    logic [WIDTH-1:0]     count_in;
    logic [WIDTH-1:0]     cmp_val;
    logic                 cmp_en;
    logic                 cap_in;
    logic                 cap_pol;
    logic [2:0]           ie;
    logic [2:0]           clr;
    logic                 tf;
    logic                 cf;
    logic                 capf;
    logic                 cap_ovr;
    logic [WIDTH-1:0]     cap_val;
    logic [OVC_WIDTH-1:0] ovf_cnt;
    logic                 reload_req;
    logic                 irq;

    modport master (
        output count_in, cmp_val, cmp_en, cap_in, cap_pol, ie, clr,
        input  tf, cf, capf, cap_ovr, cap_val, ovf_cnt, reload_req, irq
    );

    modport slave (
        input  count_in, cmp_val, cmp_en, cap_in, cap_pol, ie, clr,
        output tf, cf, capf, cap_ovr, cap_val, ovf_cnt, reload_req, irq
    );
endinterface

// File: rtl/timer_event_unit.sv
// Overflow / compare-match / pin-capture event detection for a free-running counter,
// with sticky flags, software clears, a saturating overflow count and one interrupt line.
module timer_event_unit #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned OVC_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    timer_event_unit_if.slave evt_if
);
    localparam logic [WIDTH-1:0]     CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]     CNT_ZERO = '0;
    localparam logic [OVC_WIDTH-1:0] OVC_MAX = {OVC_WIDTH{1'b1}};

    logic [WIDTH-1:0]     prev_count_q, prev_count_d;
    logic                 prev_valid_q, prev_valid_d;
    logic                 s1_q, s2_q, s3_q;
    logic                 tf_q, tf_d;
    logic                 cf_q, cf_d;
    logic                 capf_q, capf_d;
    logic                 cap_ovr_q, cap_ovr_d;
    logic [WIDTH-1:0]     cap_val_q, cap_val_d;
    logic [OVC_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
    logic                 reload_q, reload_d;
    logic                 irq_q, irq_d;

    logic ovf_ev, cmp_ev, cap_ev, cap_rise, cap_fall;

    // Event detection; prev_valid blocks false events on the first edge after reset.
    always_comb begin
        ovf_ev   = prev_valid_q && (prev_count_q == CNT_MAX) && (evt_if.count_in == CNT_ZERO);
        cmp_ev   = evt_if.cmp_en && prev_valid_q && (evt_if.count_in == evt_if.cmp_val)
                   && (prev_count_q != evt_if.cmp_val);
        cap_rise = s2_q && !s3_q;
        cap_fall = !s2_q && s3_q;
        cap_ev   = evt_if.cap_pol ? cap_rise : cap_fall;
    end

    // Next state: a set in the same cycle as a clear wins.
    always_comb begin
        prev_count_d = evt_if.count_in;
        prev_valid_d = 1'b1;
        tf_d         = ovf_ev || (tf_q && !evt_if.clr[0]);
        cf_d         = cmp_ev || (cf_q && !evt_if.clr[1]);
        capf_d       = cap_ev || (capf_q && !evt_if.clr[2]);
        cap_ovr_d    = (cap_ev && capf_q && !evt_if.clr[2]) || (cap_ovr_q && !evt_if.clr[2]);
        cap_val_d    = cap_ev ? evt_if.count_in : cap_val_q;
        reload_d     = ovf_ev;
        ovf_cnt_d    = ovf_cnt_q;
        if (ovf_ev && (ovf_cnt_q != OVC_MAX)) begin
            ovf_cnt_d = ovf_cnt_q + OVC_WIDTH'(1);
        end
        irq_d        = |({capf_d, cf_d, tf_d} & evt_if.ie);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_count_q <= '0;
            prev_valid_q <= 1'b0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            tf_q         <= 1'b0;
            cf_q         <= 1'b0;
            capf_q       <= 1'b0;
            cap_ovr_q    <= 1'b0;
            cap_val_q    <= '0;
            ovf_cnt_q    <= '0;
            reload_q     <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            prev_count_q <= prev_count_d;
            prev_valid_q <= prev_valid_d;
            s1_q         <= evt_if.cap_in;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            tf_q         <= tf_d;
            cf_q         <= cf_d;
            capf_q       <= capf_d;
            cap_ovr_q    <= cap_ovr_d;
            cap_val_q    <= cap_val_d;
            ovf_cnt_q    <= ovf_cnt_d;
            reload_q     <= reload_d;
            irq_q        <= irq_d;
        end
    end

    assign evt_if.tf         = tf_q;
    assign evt_if.cf         = cf_q;
    assign evt_if.capf       = capf_q;
    assign evt_if.cap_ovr    = cap_ovr_q;
    assign evt_if.cap_val    = cap_val_q;
    assign evt_if.ovf_cnt    = ovf_cnt_q;
    assign evt_if.reload_req = reload_q;
    assign evt_if.irq        = irq_q;
endmodule

// File: doc/timer_event_unit.md
Name: timer_event_unit

Overview:
- Downstream consumer of the 16-bit timer/counter `count` bus.
- Detects counter overflow (FFFF->0000) and compare matches, and captures `count` on an external pin edge.
- Holds sticky status flags with per-flag enables and software clears, and drives a single interrupt request plus an optional reload-request pulse.
- Sits between the timer/counter core and the interrupt/CPU interface.

Parameters:
- WIDTH, 16, width of count_in, cmp_val and cap_val.
- OVC_WIDTH, 8, width of the saturating overflow event counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- count_in  in  WIDTH  live count from the timer/counter core.
- cmp_val  in  WIDTH  compare value.
- cmp_en  in  1  enables compare-match detection.
- cap_in  in  1  external capture pin, asynchronous to clk.
- cap_pol  in  1  capture edge select: 1 = rising, 0 = falling.
- ie  in  3  interrupt enables {cap, cmp, ovf}.
- clr  in  3  one-cycle clear strobes {cap, cmp, ovf}; also clr_ovr = clr[2].
- tf  out  1  overflow flag, sticky.
- cf  out  1  compare flag, sticky.
- capf  out  1  capture flag, sticky.
- cap_ovr  out  1  capture overrun flag, sticky.
- cap_val  out  WIDTH  captured count.
- ovf_cnt  out  OVC_WIDTH  number of overflows, saturating.
- reload_req  out  1  one-cycle pulse on overflow.
- irq  out  1  interrupt request.

Behaviour:
- Reset (reset=0, asynchronous):
  - tf, cf, capf, cap_ovr, reload_req = 0; cap_val = 0; ovf_cnt = 0.
  - prev_count = 0; prev_valid = 0; sync chain = 0; irq = 0.
- Every posedge: prev_count <= count_in; prev_valid <= 1.
- Overflow event (ovf_ev):
  - ovf_ev = prev_valid & (prev_count == all-ones) & (count_in == 0).
  - Registered at the same edge: tf <= 1, reload_req <= 1 for exactly one cycle, and ovf_cnt <= ovf_cnt+1 unless ovf_cnt is all-ones (saturates, no wrap).
  - Visible latency: one cycle after count_in is first sampled as 0000.
  - No detection in the first cycle after reset release (prev_valid = 0).
  - A stalled count at 0000 does not retrigger.
- Compare event (cmp_ev):
  - cmp_ev = cmp_en & prev_valid & (count_in == cmp_val) & (prev_count != cmp_val).
  - Edge-of-match: a held count does not retrigger.
  - If cmp_val changes to equal the current count, it fires once.
  - cf <= 1 at that edge.
- Capture path:
  - cap_in passes through a 2-flop synchronizer (s1, s2), then a third flop s3.
  - Rising edge = s2 & ~s3; falling edge = ~s2 & s3. cap_pol selects which one is cap_ev.
  - On cap_ev: cap_val <= count_in, capf <= 1.
  - If capf is already 1 and not being cleared in that cycle: cap_ovr <= 1; cap_val is still overwritten.
  - Latency: 3 posedges from a pin transition meeting setup to cap_val/capf update.
- Flag clears:
  - clr[i] high at a posedge clears the corresponding flag.
  - clr[2] also clears cap_ovr.
  - Simultaneous set and clear on the same flag: set wins (flag stays/becomes 1).
- irq:
  - Registered: irq <= |({capf_next, cf_next, tf_next} & ie).
  - irq rises in the same cycle the flag becomes visible.
  - Changing ie affects irq at the next edge.
  - cap_ovr does not drive irq.
- Mid-operation reset: asserting reset at any time forces all outputs to their reset values asynchronously. After release, the first edge only primes prev_count.
- WIDTH arithmetic:
  - Equality compares are full-width and unsigned.
  - ovf_cnt increment is OVC_WIDTH-bit, saturating at 2^OVC_WIDTH-1.

Test Plan:
- **Overflow:** reset=1, count_in steps FFFD,FFFE,FFFF,0000,0001 with ie=001 -> tf=1 and irq=1 in the cycle after 0000 is sampled; reload_req high for exactly one cycle; ovf_cnt=1.
- **Compare and hold:** cmp_en=1, cmp_val=0010, ie=010, count_in 000E,000F,0010 held 4 cycles -> cf set once, one cycle after 0010 is sampled. Then clr=010 -> cf=0 and irq=0, with no re-set while 0010 is held.
- **Capture overrun:** cap_pol=1, count_in=1234, cap_in rises -> cap_val=1234 and capf=1 three edges later. A second rise at count_in=5678 without a clear -> cap_val=5678, cap_ovr=1. Then clr=100 -> capf=0, cap_ovr=0.
- **Set/clear collision:** overflow event and clr[0] in the same cycle -> tf=1. Also: 256 overflows with OVC_WIDTH=8 -> ovf_cnt sticks at FF.
- **Reset mid-operation:** reset=0 with tf, cf and capf set and count_in=FFFF -> all flags, cap_val, ovf_cnt and irq are 0 immediately. Release with count_in=0000 -> no tf on the first edge.
- **Interrupt masking:** ie=000 with all flags set -> irq=0. Then set ie=101 -> irq=1 at the next edge.
